input_event_conditioner: RTL and testbench

- Upstream front-end for the count-to-fifteen controller/datapath, which consumes `start` and `x`.
- Takes two raw, asynchronous, bouncy inputs (`raw_start`, `raw_x`) and produces clean single-cycle pulses.
- Each pulse makes the downstream counter advance exactly once per physical event, instead of once per clock while the input is held high.
- Also keeps a saturating count of accepted x events for debug.

---
 rtl/input_event_conditioner.sv | 148 ++++++++++++++
 tb/tb_input_event_conditioner.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_event_conditioner.sv
// Debounced, synchronized pulse front-end for the start/x inputs of
// the count-to-fifteen controller; also keeps a saturating x tally.

module input_event_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = 3
) (
   input  logic clock,
   input  logic clear,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam logic [1:0] ST_LOW  = 2'b00;
   localparam logic [1:0] ST_CHKH = 2'b01;
   localparam logic [1:0] ST_HIGH = 2'b10;
   localparam logic [1:0] ST_CHKL = 2'b11;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic s1;
   logic s2;
   logic [1:0] state;
   logic [1:0] state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic pulse_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pulse_nx = 1'b0;
      unique case (state)
         ST_LOW: begin
            if (s2) begin
               state_nx = ST_CHKH;
               cnt_nx   = ONE;
            end
         end
         ST_CHKH: begin
            if (!s2) begin
               state_nx = ST_LOW;
               cnt_nx   = '0;
            end else if (cnt == LIMIT) begin
               state_nx = ST_HIGH;
               cnt_nx   = '0;
               pulse_nx = 1'b1;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         ST_HIGH: begin
            if (!s2) begin
               state_nx = ST_CHKL;
               cnt_nx   = ONE;
            end
         end
         ST_CHKL: begin
            if (s2) begin
               state_nx = ST_HIGH;
               cnt_nx   = '0;
            end else if (cnt == LIMIT) begin
               state_nx = ST_LOW;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         default: begin
            state_nx = ST_LOW;
            cnt_nx   = '0;
         end
      endcase
   end

   // Everything moves on the falling edge to line up with the consumer.
   always_ff @(negedge clock) begin
      if (!clear) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= ST_LOW;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         state <= state_nx;
         cnt   <= cnt_nx;
         pulse <= pulse_nx;
      end
   end

   // HIGH and CHK_L share the upper state bit, so level is a plain flop.
   assign level = state[1];

endmodule

module input_event_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = 3
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       raw_start,
   input  logic       raw_x,
   output logic       start_pulse,
   output logic       x_pulse,
   output logic       start_level,
   output logic       x_level,
   output logic [7:0] x_count
);

   input_event_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
   ) u_start (
      .clock(clock),
      .clear(clear),
      .raw(raw_start),
      .level(start_level),
      .pulse(start_pulse)
   );

   input_event_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
   ) u_x (
      .clock(clock),
      .clear(clear),
      .raw(raw_x),
      .level(x_level),
      .pulse(x_pulse)
   );

   // A start in the same cycle wins and drops the coincident x event.
   always_ff @(negedge clock) begin
      if (!clear) begin
         x_count <= 8'd0;
      end else if (start_pulse) begin
         x_count <= 8'd0;
      end else if (x_pulse && (x_count != 8'hFF)) begin
         x_count <= x_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_input_event_conditioner.sv
// Self-checking bench for input_event_conditioner: pulse timing via
// expected-cycle queues, levels and x_count checked inside each task.

module tb_input_event_conditioner;

   localparam int D = 4;
   localparam int LAT = D + 2;

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic       raw_start = 1'b0;
   logic       raw_x = 1'b0;
   logic       start_pulse;
   logic       x_pulse;
   logic       start_level;
   logic       x_level;
   logic [7:0] x_count;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int xq[$];
   int sq[$];

   input_event_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(3)
   ) dut (
      .clock(clock),
      .clear(clear),
      .raw_start(raw_start),
      .raw_x(raw_x),
      .start_pulse(start_pulse),
      .x_pulse(x_pulse),
      .start_level(start_level),
      .x_level(x_level),
      .x_count(x_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) cyc <= cyc + 1;

   // Pulse scoreboard: sampled on the rising edge, away from DUT updates.
   always @(posedge clock) begin
      if (x_pulse === 1'b1) begin
         n_checks++;
         if (xq.size() == 0) begin
            n_fail++;
            $display("FAIL x_pulse_unexpected: got pulse at edge %0d, required none", cyc);
         end else begin
            int e;
            e = xq.pop_front();
            if (e != cyc) begin
               n_fail++;
               $display("FAIL x_pulse_time: got edge %0d, required %0d", cyc, e);
            end
         end
      end else if (xq.size() > 0 && xq[0] <= cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL x_pulse_missing: none by edge %0d, required at %0d", cyc, xq[0]);
         void'(xq.pop_front());
      end
      if (start_pulse === 1'b1) begin
         n_checks++;
         if (sq.size() == 0) begin
            n_fail++;
            $display("FAIL start_pulse_unexpected: got pulse at edge %0d, required none", cyc);
         end else begin
            int e;
            e = sq.pop_front();
            if (e != cyc) begin
               n_fail++;
               $display("FAIL start_pulse_time: got edge %0d, required %0d", cyc, e);
            end
         end
      end else if (sq.size() > 0 && sq[0] <= cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL start_pulse_missing: none by edge %0d, required at %0d", cyc, sq[0]);
         void'(sq.pop_front());
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
   endtask

   // Drive one raw event; called at a rising edge, input sampled next fall.
   task automatic pulse_in(input bit is_x, input int hi, input int lo,
                           input bit expect_pulse);
      if (is_x) raw_x = 1'b1;
      else raw_start = 1'b1;
      if (expect_pulse) begin
         if (is_x) xq.push_back(cyc + 1 + LAT);
         else sq.push_back(cyc + 1 + LAT);
      end
      wait_cyc(hi);
      if (is_x) raw_x = 1'b0;
      else raw_start = 1'b0;
      wait_cyc(lo);
   endtask

   task automatic test_reset();
      clear = 1'b0;
      wait_cyc(3);
      n_checks++;
      if ({start_pulse, x_pulse, start_level, x_level} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 0000",
                  {start_pulse, x_pulse, start_level, x_level});
      end
      n_checks++;
      if (x_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d, required 0", x_count);
      end
      clear = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_latency();
      int k;
      raw_x = 1'b1;
      k = cyc + 1;
      xq.push_back(k + LAT);
      for (int i = 0; i < 10; i++) begin
         logic exp_lvl;
         @(posedge clock);
         exp_lvl = (cyc >= k + LAT);
         n_checks++;
         if (x_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL latency_level: edge %0d got %b, required %b", cyc, x_level, exp_lvl);
         end
      end
      n_checks++;
      if (x_count !== 8'd1) begin
         n_fail++;
         $display("FAIL latency_count: got %0d, required 1", x_count);
      end
      raw_x = 1'b0;
      wait_cyc(12);
      n_checks++;
      if (x_level !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_fall_level: got %b, required 0", x_level);
      end
   endtask

   task automatic test_glitch();
      pulse_in(1'b0, 8, 12, 1'b1);
      n_checks++;
      if (x_count !== 8'd0) begin
         n_fail++;
         $display("FAIL glitch_start_clear: got %0d, required 0", x_count);
      end
      raw_x = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clock);
         if (i == 2) raw_x = 1'b0;
         n_checks++;
         if (x_level !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch3_level: step %0d got %b, required 0", i, x_level);
         end
      end
      pulse_in(1'b1, D, 12, 1'b0);
      n_checks++;
      if (x_count !== 8'd0) begin
         n_fail++;
         $display("FAIL glitch_d_count: got %0d, required 0", x_count);
      end
      pulse_in(1'b1, D + 1, 12, 1'b1);
      n_checks++;
      if (x_count !== 8'd1) begin
         n_fail++;
         $display("FAIL glitch_d1_count: got %0d, required 1", x_count);
      end
      raw_x = 1'b1;
      xq.push_back(cyc + 1 + LAT);
      wait_cyc(10);
      raw_x = 1'b0;
      wait_cyc(3);
      raw_x = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         n_checks++;
         if (x_level !== 1'b1) begin
            n_fail++;
            $display("FAIL low_glitch_level: step %0d got %b, required 1", i, x_level);
         end
      end
      raw_x = 1'b0;
      wait_cyc(12);
      n_checks++;
      if (x_count !== 8'd2) begin
         n_fail++;
         $display("FAIL low_glitch_count: got %0d, required 2", x_count);
      end
   endtask

   task automatic test_train();
      pulse_in(1'b0, 8, 12, 1'b1);
      for (int i = 0; i < 5; i++) pulse_in(1'b1, 8, 8, 1'b1);
      wait_cyc(4);
      n_checks++;
      if (x_count !== 8'd5) begin
         n_fail++;
         $display("FAIL train_count: got %0d, required 5", x_count);
      end
   endtask

   task automatic test_simultaneous();
      pulse_in(1'b0, 8, 12, 1'b1);
      for (int i = 0; i < 3; i++) pulse_in(1'b1, 8, 8, 1'b1);
      n_checks++;
      if (x_count !== 8'd3) begin
         n_fail++;
         $display("FAIL simul_pre_count: got %0d, required 3", x_count);
      end
      raw_start = 1'b1;
      raw_x = 1'b1;
      xq.push_back(cyc + 1 + LAT);
      sq.push_back(cyc + 1 + LAT);
      wait_cyc(10);
      n_checks++;
      if ({start_level, x_level} !== 2'b11) begin
         n_fail++;
         $display("FAIL simul_levels: got %b, required 11", {start_level, x_level});
      end
      raw_start = 1'b0;
      raw_x = 1'b0;
      wait_cyc(12);
      n_checks++;
      if (x_count !== 8'd0) begin
         n_fail++;
         $display("FAIL simul_count: got %0d, required 0", x_count);
      end
   endtask

   task automatic test_saturate();
      pulse_in(1'b0, 8, 12, 1'b1);
      for (int i = 0; i < 260; i++) begin
         pulse_in(1'b1, 8, 8, 1'b1);
         if (i == 253) begin
            n_checks++;
            if (x_count !== 8'd254) begin
               n_fail++;
               $display("FAIL sat_254: got %0d, required 254", x_count);
            end
         end
         if (i == 254 || i == 259) begin
            n_checks++;
            if (x_count !== 8'd255) begin
               n_fail++;
               $display("FAIL sat_hold: event %0d got %0d, required 255", i + 1, x_count);
            end
         end
      end
   endtask

   task automatic test_clear_mid();
      raw_x = 1'b1;
      wait_cyc(4);
      clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         n_checks++;
         if ({start_pulse, x_pulse, start_level, x_level, x_count} !== 12'd0) begin
            n_fail++;
            $display("FAIL clear_mid_outputs: step %0d got %b/%0d, required 0000/0", i,
                     {start_pulse, x_pulse, start_level, x_level}, x_count);
         end
      end
      clear = 1'b1;
      xq.push_back(cyc + 1 + LAT);
      wait_cyc(12);
      raw_x = 1'b0;
      wait_cyc(12);
      n_checks++;
      if (x_count !== 8'd1) begin
         n_fail++;
         $display("FAIL clear_mid_count: got %0d, required 1", x_count);
      end
   endtask

   task automatic test_drain();
      wait_cyc(4);
      n_checks++;
      if (xq.size() != 0 || sq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending, required 0/0", xq.size(), sq.size());
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_train();
      test_simultaneous();
      test_saturate();
      test_clear_mid();
      test_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
